// File: rtl/display_mem_dp.sv
// Dual-port display memory: A read/write, B read-only, built-in clear sequencer.
// Read latency RD_LAT (1 or 2) cycles; no backpressure, ports are ignored while busy.
module display_mem_dp #(
  parameter int                 DATA_W     = 16,
  parameter int                 ADDR_W     = 12,
  parameter logic [DATA_W-1:0]  CLEAR_VAL  = '0,
  parameter int                 RD_LAT     = 1,
  parameter int                 WRITE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              douta_vld,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              doutb_vld
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              acc_a, wr_a, acc_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] rda_nxt, rdb_nxt;

  logic [DATA_W-1:0] a1_dat, b1_dat;
  logic              a1_vld, b1_vld;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR) | rst;
  assign idle  = (state == IDLE) & ~rst;
  assign acc_a = idle & ena;
  assign wr_a  = acc_a & wea;
  assign acc_b = idle & enb;

  // ---------------------------------------------------------------- storage
  // Clear and port A writes never coexist, so one write port serves both.
  assign mem_we    = ~rst & (clr_we | wr_a);
  assign mem_waddr = clr_we ? cnt : addra;
  assign mem_wdat  = clr_we ? CLEAR_VAL : dina;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  // Write-first mode forwards dina to any read of the address being written.
  assign rda_nxt = (WRITE_MODE == 1 && wr_a) ? dina : mem[addra];
  assign rdb_nxt = (WRITE_MODE == 1 && wr_a && addra == addrb) ? dina : mem[addrb];

  // ---------------------------------------------------------------- read stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_dat <= '0;
      a1_vld <= 1'b0;
      b1_dat <= '0;
      b1_vld <= 1'b0;
    end else begin
      a1_vld <= acc_a;
      b1_vld <= acc_b;
      if (acc_a) begin
        a1_dat <= rda_nxt;
      end
      if (acc_b) begin
        b1_dat <= rdb_nxt;
      end
    end
  end

  // ---------------------------------------------------------------- optional stage 2
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] a2_dat, b2_dat;
      logic              a2_vld, b2_vld;

      // Free-running: stage 1 already holds data between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          a2_dat <= '0;
          a2_vld <= 1'b0;
          b2_dat <= '0;
          b2_vld <= 1'b0;
        end else begin
          a2_dat <= a1_dat;
          a2_vld <= a1_vld;
          b2_dat <= b1_dat;
          b2_vld <= b1_vld;
        end
      end

      assign douta     = a2_dat;
      assign douta_vld = a2_vld;
      assign doutb     = b2_dat;
      assign doutb_vld = b2_vld;
    end else begin : g_lat1
      assign douta     = a1_dat;
      assign douta_vld = a1_vld;
      assign doutb     = b1_dat;
      assign doutb_vld = b1_vld;
    end
  endgenerate

endmodule

// File: doc/display_mem_dp.md
# display_mem_dp

Parametrised single-clock dual-port memory for the display controller: port A is a read/write port for the game logic, and port B is a read-only port for the display scan. It generalises our fixed 16x16 block-memory usage in four ways: configurable width and depth, configurable read latency, a selectable collision mode, and a built-in clear sequencer. The clear sequencer fills every word with a constant after reset or on request, so no memory-initialisation file is needed.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words
- CLEAR_VAL, 0, DATA_W-bit value written by the clear sequencer
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 only
- WRITE_MODE, 0, collision mode; 0 = read-first (old data), 1 = write-first (new data)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  one-cycle request to clear the whole memory; honoured only when idle
- busy  out  1  high while a clear runs or rst is high
- ena  in  1  port A enable
- wea  in  1  port A write enable; qualified by ena
- addra  in  ADDR_W  port A address
- dina  in  DATA_W  port A write data
- douta  out  DATA_W  port A read data
- douta_vld  out  1  port A read-data strobe
- enb  in  1  port B read enable
- addrb  in  ADDR_W  port B address
- doutb  out  DATA_W  port B read data
- doutb_vld  out  1  port B read-data strobe

## Operation
- State machine has two states, CLEAR and IDLE; busy = (state == CLEAR) | rst.
- While rst is high:
  - state <= CLEAR, clear counter cnt <= 0.
  - douta, doutb, douta_vld, doutb_vld and all pipeline registers <= 0.
  - Memory contents are not modified.
- CLEAR, on each edge with rst low:
  - mem[cnt] <= CLEAR_VAL, cnt <= cnt + 1.
  - After the edge that writes DEPTH-1, state <= IDLE and cnt wraps to 0.
- IDLE:
  - clr_req = 1 gives state <= CLEAR and cnt <= 0.
  - A port A access presented on that same edge is still performed.
- clr_req is ignored while in CLEAR; the clear does not restart.
- While busy, ena and enb are ignored: no write, no read, no strobe.
  - Strobes already in the RD_LAT=2 pipeline still complete.
- Port A access (IDLE, ena = 1):
  - Always performs a read of addra.
  - If wea = 1, it also performs mem[addra] <= dina.
  - On a write, douta returns the old word when WRITE_MODE=0, or dina when WRITE_MODE=1.
- Port B access (IDLE, enb = 1): reads addrb.
- Cross-port collision (A writes address X while B reads X on the same edge):
  - doutb = old word when WRITE_MODE=0, dina when WRITE_MODE=1.
- douta and doutb hold their last value when no new read completes.
- douta_vld and doutb_vld are one-cycle pulses per access.
- Reset asserted mid-clear: the clear restarts from address 0 once rst falls.

## Timing
- RD_LAT=1: an access accepted on edge N drives dout and vld after edge N.
  - Fully pipelined; one access per port per cycle, back-to-back.
- RD_LAT=2: the same access appears after edge N+1.
  - The extra register stage is enabled every cycle.
- Clear duration: if rst is first sampled low on edge 1, busy is high until after edge DEPTH.
  - The first accepted port access is on edge DEPTH+1.
- clr_req accepted on edge N: busy rises after edge N.
  - Accesses on edges N+1 through N+DEPTH are dropped.
- Port A write visibility: a write on edge N is visible to any read on edge N+1 or later, on either port.
- There is no reset of memory contents other than via the clear sequencer.

## Test plan
- Reset and clear, ADDR_W=4, CLEAR_VAL=16'hA5A5:
  - Hold rst for 3 cycles, then release.
  - busy stays high for exactly 16 edges.
  - Reading all 16 addresses on port B returns 16'hA5A5 with doutb_vld pulses.
- Write/read with RD_LAT=1, then RD_LAT=2:
  - Write 16'h1234 to address 5.
  - Reading address 5 on the next cycle on both ports returns 16'h1234 after 1 or 2 edges respectively.
  - vld pulses align with the data.
- Same-address collision:
  - Preload address 3 with 16'h0001, then A writes 16'h00FF to address 3 while B reads address 3.
  - WRITE_MODE=0 gives douta = doutb = 16'h0001; WRITE_MODE=1 gives 16'h00FF for both.
  - Address 3 afterwards holds 16'h00FF in both modes.
- clr_req during traffic:
  - Pulse clr_req alongside an A write of 16'hBEEF to address 2.
  - The write occurs, then busy rises for DEPTH cycles.
  - ena and enb pulses during busy produce no strobes.
  - Afterwards, address 2 reads CLEAR_VAL.
- Reset mid-clear:
  - Assert rst when cnt = 7, then release.
  - busy lasts a full DEPTH cycles again.
  - All addresses read CLEAR_VAL afterwards.
- Streaming:
  - 64 back-to-back port B reads of addresses 0..63, with port A writing in parallel.
  - Every cycle produces one doutb_vld with the correct data; no gaps.
